// File: rtl/wb_interconnect_nslv.sv
// Single-master Wishbone interconnect fanning out to NUM_SLAVES ports by top address bits.
// Unmapped slots and unresponsive slaves terminate with a one-cycle error and are counted.
module wb_interconnect_nslv #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADDR_WIDTH-1:0]            M_ADR_O,
  input  logic [DATA_WIDTH-1:0]            M_DAT_O,
  input  logic                             M_WE_O,
  input  logic [DATA_WIDTH/8-1:0]          M_SEL_O,
  input  logic                             M_STB_O,
  input  logic                             M_CYC_O,
  output logic [DATA_WIDTH-1:0]            M_DAT_I,
  output logic                             M_ACK_I,
  output logic                             M_ERR_I,
  output logic [ADDR_WIDTH-1:0]            S_ADR_I,
  output logic [DATA_WIDTH-1:0]            S_DAT_I,
  output logic                             S_WE_I,
  output logic [DATA_WIDTH/8-1:0]          S_SEL_I,
  output logic [NUM_SLAVES-1:0]            S_STB_I,
  output logic [NUM_SLAVES-1:0]            S_CYC_I,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] S_DAT_O,
  input  logic [NUM_SLAVES-1:0]            S_ACK_O,
  output logic [7:0]                       err_count_o
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] req_idx;
  logic [CNT_W-1:0] tmo_q;
  logic [CNT_W-1:0] tmo_inc;
  logic [7:0]       err_inc;
  logic             req;
  logic             idx_ok;
  logic             active;
  logic             slv_ack;

  assign req_idx = M_ADR_O[ADDR_WIDTH-1 -: IDX_W];
  assign req     = M_CYC_O & M_STB_O;
  assign idx_ok  = 32'(req_idx) < NUM_SLAVES;
  assign active  = (state_q == ACTIVE);
  assign tmo_inc = tmo_q + CNT_W'(1);
  assign err_inc = (err_count_o == 8'hFF) ? err_count_o : err_count_o + 8'd1;

  // Shared request lines go to every slave unconditionally
  assign S_ADR_I = M_ADR_O;
  assign S_DAT_I = M_DAT_O;
  assign S_WE_I  = M_WE_O;
  assign S_SEL_I = M_SEL_O;

  // Only the latched slave sees strobe/cycle, and only its ack/data come back
  always_comb begin
    S_STB_I = '0;
    S_CYC_I = '0;
    M_DAT_I = '0;
    slv_ack = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (active && (sel_q == IDX_W'(i))) begin
        S_STB_I[i] = M_STB_O;
        S_CYC_I[i] = M_CYC_O;
        M_DAT_I    = S_DAT_O[i*DATA_WIDTH +: DATA_WIDTH];
        slv_ack    = S_ACK_O[i];
      end
    end
  end

  // Ack requires a live cycle so an aborting master never sees a termination
  assign M_ACK_I = active & M_CYC_O & M_STB_O & slv_ack;
  assign M_ERR_I = (state_q == ERROR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      tmo_q       <= '0;
      err_count_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            sel_q <= req_idx;
            tmo_q <= '0;
            if (idx_ok) begin
              state_q <= ACTIVE;
            end else begin
              state_q     <= ERROR;
              err_count_o <= err_inc;
            end
          end
        end
        ACTIVE: begin
          if (!M_CYC_O) begin
            state_q <= IDLE;
            tmo_q   <= '0;
          end else if (M_ACK_I) begin
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_inc;
            if (tmo_inc == CNT_W'(TIMEOUT_CYCLES)) begin
              state_q     <= ERROR;
              err_count_o <= err_inc;
            end
          end
        end
        ERROR: begin
          state_q <= IDLE;
          tmo_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_interconnect_nslv.sv
// Bench for wb_interconnect_nslv: a 4-slave and a 3-slave instance share master stimulus,
// with expected terminations queued at issue time and checked when the DUT responds.
module tb_wb_interconnect_nslv;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  m_adr = '0;
  logic [31:0]  m_wdat = '0;
  logic         m_we = 1'b0;
  logic [3:0]   m_sel = '0;
  logic         m_stb = 1'b0;
  logic         m_cyc = 1'b0;
  logic         use3 = 1'b0;
  logic [3:0]   s_ack_drv = '0;
  logic [127:0] s_dat_drv = '0;

  logic         m_cyc4, m_cyc3;
  logic [31:0]  d4_dat, d3_dat, s4_adr, s3_adr, s4_dat, s3_dat;
  logic         d4_ack, d3_ack, d4_err, d3_err, s4_we, s3_we;
  logic [3:0]   s4_sel, s3_sel, s4_stb, s4_cyc, s4_ack_o;
  logic [2:0]   s3_stb, s3_cyc, s3_ack_o;
  logic [7:0]   d4_cnt, d3_cnt;

  assign m_cyc4   = m_cyc & ~use3;
  assign m_cyc3   = m_cyc & use3;
  assign s4_ack_o = use3 ? 4'b0 : s_ack_drv;
  assign s3_ack_o = use3 ? s_ack_drv[2:0] : 3'b0;

  wb_interconnect_nslv #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .TIMEOUT_CYCLES(8)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .M_ADR_O(m_adr), .M_DAT_O(m_wdat), .M_WE_O(m_we), .M_SEL_O(m_sel), .M_STB_O(m_stb), .M_CYC_O(m_cyc4),
    .M_DAT_I(d4_dat), .M_ACK_I(d4_ack), .M_ERR_I(d4_err),
    .S_ADR_I(s4_adr), .S_DAT_I(s4_dat), .S_WE_I(s4_we), .S_SEL_I(s4_sel),
    .S_STB_I(s4_stb), .S_CYC_I(s4_cyc), .S_DAT_O(s_dat_drv), .S_ACK_O(s4_ack_o),
    .err_count_o(d4_cnt)
  );

  wb_interconnect_nslv #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3), .TIMEOUT_CYCLES(8)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .M_ADR_O(m_adr), .M_DAT_O(m_wdat), .M_WE_O(m_we), .M_SEL_O(m_sel), .M_STB_O(m_stb), .M_CYC_O(m_cyc3),
    .M_DAT_I(d3_dat), .M_ACK_I(d3_ack), .M_ERR_I(d3_err),
    .S_ADR_I(s3_adr), .S_DAT_I(s3_dat), .S_WE_I(s3_we), .S_SEL_I(s3_sel),
    .S_STB_I(s3_stb), .S_CYC_I(s3_cyc), .S_DAT_O(s_dat_drv[95:0]), .S_ACK_O(s3_ack_o),
    .err_count_o(d3_cnt)
  );

  // Observation view of whichever instance is under test
  logic        o_ack, o_err, o_swe;
  logic [31:0] o_dat, o_sadr, o_sdat;
  logic [3:0]  o_ssel, o_stb, o_cyc;
  logic [7:0]  o_cnt;
  assign o_ack  = use3 ? d3_ack : d4_ack;
  assign o_err  = use3 ? d3_err : d4_err;
  assign o_dat  = use3 ? d3_dat : d4_dat;
  assign o_sadr = use3 ? s3_adr : s4_adr;
  assign o_sdat = use3 ? s3_dat : s4_dat;
  assign o_swe  = use3 ? s3_we : s4_we;
  assign o_ssel = use3 ? s3_sel : s4_sel;
  assign o_stb  = use3 ? {1'b0, s3_stb} : s4_stb;
  assign o_cyc  = use3 ? {1'b0, s3_cyc} : s4_cyc;
  assign o_cnt  = use3 ? d3_cnt : d4_cnt;

  int   total = 0;
  int   bad = 0;
  int   exp_cnt4 = 0;
  int   exp_cnt3 = 0;
  exp_t sb[$];

  task automatic xact(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [3:0] sel, input int ack_cyc, input logic [31:0] rdat,
                      input logic exp_err, input int exp_cycle, input string nm);
    int   slv;
    int   n;
    bit   done;
    exp_t e;
    logic [3:0] oh;
    slv = int'(adr[31:30]);
    oh  = 4'b0001 << slv;
    e.is_err = exp_err;
    e.data   = exp_err ? 32'h0 : rdat;
    sb.push_back(e);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) s_dat_drv[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
    s_dat_drv[slv*32 +: 32] = rdat;
    s_ack_drv = ~oh;
    m_adr = adr; m_we = we; m_wdat = wdat; m_sel = sel; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk);
    total++;
    if (o_stb !== 4'b0 || o_ack !== 1'b0) begin
      bad++; $display("FAIL %s idle_cycle stb=%b ack=%b exp stb=0000 ack=0", nm, o_stb, o_ack);
    end
    total++;
    if ({o_sadr, o_sdat, o_swe, o_ssel} !== {adr, wdat, we, sel}) begin
      bad++; $display("FAIL %s passthru adr=%h dat=%h we=%b sel=%b exp %h %h %b %b",
                      nm, o_sadr, o_sdat, o_swe, o_ssel, adr, wdat, we, sel);
    end
    done = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      s_ack_drv = (ack_cyc != 0 && n == ack_cyc) ? 4'b1111 : ~oh;
      @(negedge clk);
      total++;
      if (o_ack && o_err) begin
        bad++; $display("FAIL %s ack_and_err both high at cycle %0d", nm, n);
      end
      if (o_ack || o_err) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          total++; bad++; $display("FAIL %s scoreboard empty on response", nm);
        end else begin
          e = sb.pop_front();
          total++;
          if (o_err !== e.is_err) begin
            bad++; $display("FAIL %s resp_kind err=%b ack=%b exp err=%b", nm, o_err, o_ack, e.is_err);
          end
          total++;
          if (o_dat !== e.data) begin
            bad++; $display("FAIL %s resp_data got=%h exp=%h", nm, o_dat, e.data);
          end
          total++;
          if (n != exp_cycle) begin
            bad++; $display("FAIL %s resp_cycle got=%0d exp=%0d", nm, n, exp_cycle);
          end
          if (o_err) begin
            total++;
            if (o_stb !== 4'b0 || o_cyc !== 4'b0) begin
              bad++; $display("FAIL %s err_strobes stb=%b cyc=%b exp 0000", nm, o_stb, o_cyc);
            end
          end
        end
      end else if (n == 1 && !exp_err) begin
        total++;
        if (o_stb !== oh || o_cyc !== oh) begin
          bad++; $display("FAIL %s strobe_select stb=%b cyc=%b exp=%b", nm, o_stb, o_cyc, oh);
        end
      end
    end
    if (!done) begin
      total++; bad++; $display("FAIL %s no_response within %0d cycles", nm, n);
      void'(sb.pop_front());
    end
    if (exp_err) begin
      if (use3) exp_cnt3 = (exp_cnt3 < 255) ? exp_cnt3 + 1 : 255;
      else      exp_cnt4 = (exp_cnt4 < 255) ? exp_cnt4 + 1 : 255;
    end
  endtask

  task automatic release_bus(input string nm);
    int ec;
    @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0; s_ack_drv = '0;
    @(negedge clk);
    ec = use3 ? exp_cnt3 : exp_cnt4;
    total++;
    if (o_ack !== 1'b0 || o_err !== 1'b0 || o_stb !== 4'b0 || o_cyc !== 4'b0) begin
      bad++; $display("FAIL %s post_idle ack=%b err=%b stb=%b cyc=%b exp all 0", nm, o_ack, o_err, o_stb, o_cyc);
    end
    total++;
    if (o_cnt !== 8'(ec)) begin
      bad++; $display("FAIL %s err_count got=%0d exp=%0d", nm, o_cnt, ec);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({d4_ack, d4_err, d3_ack, d3_err, s4_stb, s4_cyc, s3_stb, s3_cyc} !== 18'b0 ||
        d4_dat !== 32'h0 || d3_dat !== 32'h0 || d4_cnt !== 8'h0 || d3_cnt !== 8'h0) begin
      bad++; $display("FAIL reset_state ack=%b%b err=%b%b stb=%b/%b dat=%h/%h cnt=%0d/%0d exp all 0",
                      d4_ack, d3_ack, d4_err, d3_err, s4_stb, s3_stb, d4_dat, d3_dat, d4_cnt, d3_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({d4_ack, d4_err, s4_stb, s4_cyc} !== 10'b0 || d4_dat !== 32'h0) begin
      bad++; $display("FAIL post_reset_idle ack=%b err=%b stb=%b dat=%h exp 0", d4_ack, d4_err, s4_stb, d4_dat);
    end
  endtask

  task automatic test_read();
    use3 = 1'b0;
    xact(32'h4000_0010, 1'b0, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 3, "read_s1");
    release_bus("read_s1");
  endtask

  task automatic test_back_to_back();
    use3 = 1'b0;
    xact(32'h0000_0000, 1'b1, 32'h1234_5678, 4'b0011, 1, 32'h0000_0000, 1'b0, 1, "write_s0");
    xact(32'hC000_0004, 1'b0, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 1'b0, 2, "b2b_s3");
    release_bus("b2b_s3");
  endtask

  task automatic test_timeout();
    use3 = 1'b0;
    xact(32'h8000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h5555_AAAA, 1'b1, 9, "timeout_s2");
    release_bus("timeout_s2");
    xact(32'h8000_0000, 1'b0, 32'h0, 4'hF, 8, 32'h600D_0008, 1'b0, 8, "ack_at_limit");
    release_bus("ack_at_limit");
  endtask

  task automatic test_decode_err();
    use3 = 1'b1;
    xact(32'hC000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h1111_1111, 1'b1, 1, "decode_err");
    release_bus("decode_err");
    xact(32'h8000_0004, 1'b0, 32'h0, 4'hF, 1, 32'h3333_0002, 1'b0, 1, "ns3_s2");
    release_bus("ns3_s2");
  endtask

  task automatic test_abort_reset();
    use3 = 1'b0;
    // master withdraws cycle while the selected slave acks in the same cycle
    @(posedge clk); #1;
    m_adr = 32'h4000_0000; m_we = 1'b0; s_ack_drv = '0; m_cyc = 1'b1; m_stb = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    m_cyc = 1'b0; m_stb = 1'b0; s_ack_drv = 4'b0010;
    @(negedge clk);
    total++;
    if (o_ack !== 1'b0 || o_err !== 1'b0 || o_cyc !== 4'b0) begin
      bad++; $display("FAIL abort_cycle ack=%b err=%b cyc=%b exp 0", o_ack, o_err, o_cyc);
    end
    release_bus("abort");
    xact(32'h4000_0000, 1'b0, 32'h0, 4'hF, 1, 32'hA5A5_0001, 1'b0, 1, "after_abort");
    release_bus("after_abort");
    // asynchronous reset while a transaction is in flight
    @(posedge clk); #1;
    m_adr = 32'h8000_0000; m_cyc = 1'b1; m_stb = 1'b1; s_ack_drv = '0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if (o_stb !== 4'b0100) begin
      bad++; $display("FAIL pre_reset_active stb=%b exp=0100", o_stb);
    end
    #2;
    rst = 1'b1; s_ack_drv = 4'b0100;
    #1;
    exp_cnt4 = 0; exp_cnt3 = 0;
    total++;
    if (o_stb !== 4'b0 || o_cyc !== 4'b0 || o_ack !== 1'b0 || o_err !== 1'b0 ||
        d4_cnt !== 8'h0 || d3_cnt !== 8'h0) begin
      bad++; $display("FAIL async_reset stb=%b cyc=%b ack=%b err=%b cnt=%0d/%0d exp all 0",
                      o_stb, o_cyc, o_ack, o_err, d4_cnt, d3_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    release_bus("after_reset");
  endtask

  task automatic test_saturation();
    use3 = 1'b1;
    for (int k = 0; k < 260; k++) begin
      xact(32'hC000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b1, 1, "sat");
      release_bus("sat");
    end
    total++;
    if (d3_cnt !== 8'd255) begin
      bad++; $display("FAIL saturation got=%0d exp=255", d3_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_timeout();
    test_decode_err();
    test_abort_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_interconnect_nslv.md
WB_INTERCONNECT_NSLV -- requirements
Module: wb_interconnect_nslv

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width; SEL width = DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_SLAVES, default 4, range 1..16, number of slave ports.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535, maximum ACTIVE cycles without ACK.
REQ-005 SHALL define IDX_W = max(1, clog2(NUM_SLAVES)); slave index = M_ADR_O[ADDR_WIDTH-1 -: IDX_W].
REQ-006 SHALL use one clock and an asynchronous, active-high reset; all state resets immediately on rst_i high.
REQ-007 clk_i  input  1  system clock.
REQ-008 rst_i  input  1  asynchronous active-high reset.
REQ-009 M_ADR_O, M_DAT_O, M_WE_O, M_SEL_O, M_STB_O, M_CYC_O  input  ADDR_WIDTH/DATA_WIDTH/1/DATA_WIDTH/8/1/1  master request signals.
REQ-010 M_DAT_I  output  DATA_WIDTH  read data to master.
REQ-011 M_ACK_I  output  1  normal termination to master.
REQ-012 M_ERR_I  output  1  error termination to master.
REQ-013 S_ADR_I, S_DAT_I, S_WE_I, S_SEL_I  output  ADDR_WIDTH/DATA_WIDTH/1/DATA_WIDTH/8  shared to all slaves.
REQ-014 S_STB_I, S_CYC_I  output  NUM_SLAVES  per-slave strobe/cycle, bit i = slave i.
REQ-015 S_DAT_O  input  NUM_SLAVES*DATA_WIDTH  flattened slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-016 S_ACK_O  input  NUM_SLAVES  per-slave acknowledge.
REQ-017 err_count_o  output  8  saturating count of error terminations.

Function
REQ-018 SHALL implement FSM with states IDLE, ACTIVE, ERROR.
REQ-019 IDLE: when M_CYC_O & M_STB_O, SHALL register index into sel_q; next state ACTIVE if index < NUM_SLAVES, else ERROR.
REQ-020 ACTIVE: S_CYC_I[sel_q] = M_CYC_O, S_STB_I[sel_q] = M_STB_O; all other bits 0.
REQ-021 S_ADR_I, S_DAT_I, S_WE_I, S_SEL_I SHALL be combinational pass-through of master signals at all times.
REQ-022 In ACTIVE, M_ACK_I = S_ACK_O[sel_q] & M_STB_O (combinational); on that cycle next state IDLE.
REQ-023 M_DAT_I SHALL equal S_DAT_O of slave sel_q in ACTIVE, else all zeros.
REQ-024 Latency: request seen in IDLE at cycle N -> slave strobe from cycle N+1; minimum transaction 2 cycles.
REQ-025 Timeout counter SHALL clear on IDLE->ACTIVE, increment each ACTIVE cycle without ACK; on reaching TIMEOUT_CYCLES, next state ERROR.
REQ-026 ACK on the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: ACK delivered, no error.
REQ-027 ERROR: M_ERR_I = 1 for exactly one cycle, all S_STB_I/S_CYC_I = 0, M_ACK_I = 0; next state IDLE.
REQ-028 Each entry into ERROR SHALL increment err_count_o, saturating at 255.
REQ-029 M_CYC_O falling in ACTIVE SHALL abort: next state IDLE, no ACK/ERR, counter cleared, err_count_o unchanged.
REQ-030 S_ACK_O bits from non-selected slaves, and any S_ACK_O in IDLE/ERROR, SHALL be ignored.
REQ-031 M_ACK_I and M_ERR_I SHALL never be high in the same cycle.
REQ-032 Back-to-back: after IDLE return, new request SHALL be accepted next cycle with fresh index decode.

Reset
REQ-033 On rst_i: state IDLE, sel_q 0, timeout counter 0, err_count_o 0.
REQ-034 During and after reset until a request: M_ACK_I 0, M_ERR_I 0, M_DAT_I 0, S_STB_I 0, S_CYC_I 0.
REQ-035 Reset asserted mid-ACTIVE SHALL drop all strobes asynchronously, with no ACK/ERR produced.

Verification
REQ-036 NUM_SLAVES=4: read M_ADR_O=0x4000_0010, slave 1 ACKs with 0xDEAD_BEEF after 3 cycles -> S_STB_I=4'b0010 from cycle N+1, M_ACK_I one cycle, M_DAT_I=0xDEAD_BEEF, others' strobes 0.
REQ-037 NUM_SLAVES=3: access 0xC000_0000 -> ERROR next cycle, M_ERR_I one cycle, no S_STB_I, err_count_o=1.
REQ-038 TIMEOUT_CYCLES=8, slave 2 never ACKs -> M_ERR_I after 8 ACTIVE cycles, S_STB_I cleared, err_count_o increments; repeat with ACK on 8th cycle -> ACK only.
REQ-039 Slave 0 write 0x1234_5678, SEL=4'b0011 -> S_DAT_I/S_SEL_I/S_WE_I match master, ACK returned; immediate next request to slave 3 -> S_STB_I=4'b1000 one cycle later.
REQ-040 M_CYC_O dropped mid-ACTIVE, and separately rst_i pulsed mid-ACTIVE -> IDLE, strobes 0, no ACK/ERR, err_count_o unchanged (0 after reset).
REQ-041 260 forced error transactions -> err_count_o saturates at 255.
